scroll_marquee: RTL and testbench

Parametrised scrolling-text engine for an N-digit multiplexed seven-segment display, in the vending-machine style. It holds a writable message buffer of raw segment patterns and generates its own refresh and scroll timing. Supports scroll-left, scroll-right, one-shot and static modes, plus hold and restart. It sits directly behind a board top level and drives `an` and `seg`, with no slow-clock module required.

---
 rtl/scroll_marquee.sv | 175 +++++++++++++++++
 tb/tb_scroll_marquee.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_marquee.sv
// Scrolling-text engine for an N-digit multiplexed seven-segment display.
// Holds a writable segment-pattern buffer and generates its own refresh and scroll timing.
module scroll_marquee #(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_MAX     = 16,
    parameter int SCROLL_DIV  = 25000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_MAX)-1:0]   wr_addr,
    input  logic [6:0]                   wr_seg,
    input  logic [$clog2(MSG_MAX):0]     cfg_len,
    input  logic [1:0]                   cfg_mode,
    input  logic                         restart,
    input  logic                         hold,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [6:0]                   seg,
    output logic                         wrap,
    output logic                         done
);

    localparam int AW = $clog2(MSG_MAX);
    localparam int LW = AW + 1;
    // Wide enough for p+k, which stays below twice the stream length.
    localparam int PW = $clog2(2 * (MSG_MAX + NUM_DIGITS));
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        MODE_LEFT    = 2'b00,
        MODE_RIGHT   = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_STATIC  = 2'b11
    } mode_t;

    logic [6:0]            msg_buf [MSG_MAX];
    logic [LW-1:0]         len_q;
    mode_t                 mode_q;
    logic [PW-1:0]         pos;
    logic [SW-1:0]         scroll_cnt;
    logic [RW-1:0]         refresh_cnt;
    logic [DW-1:0]         digit;

    logic                  tick;
    logic                  refresh_wrap;
    logic [LW-1:0]         len_clamped;
    logic [PW-1:0]         stream_len;
    logic [PW-1:0]         last_pos;
    logic [PW-1:0]         pos_nxt;
    logic                  wrap_nxt;
    logic                  done_nxt;
    logic [PW-1:0]         k_left;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         rel;
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign tick         = (scroll_cnt == SW'(SCROLL_DIV - 1));
    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign len_clamped  = (cfg_len > LW'(MSG_MAX)) ? LW'(MSG_MAX) : cfg_len;
    assign stream_len   = PW'(len_q) + PW'(NUM_DIGITS);
    assign last_pos     = stream_len - PW'(1);

    // Position sequencing; restart outranks everything, static mode pins p.
    always_comb begin
        pos_nxt  = pos;
        wrap_nxt = 1'b0;
        done_nxt = done;
        if (restart) begin
            pos_nxt  = '0;
            done_nxt = 1'b0;
        end else if (mode_q == MODE_STATIC) begin
            pos_nxt = PW'(NUM_DIGITS);
        end else if (tick && !hold) begin
            case (mode_q)
                MODE_LEFT: begin
                    if (pos == last_pos) begin
                        pos_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos + PW'(1);
                    end
                end
                MODE_RIGHT: begin
                    if (pos == '0) begin
                        pos_nxt  = last_pos;
                        wrap_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos - PW'(1);
                    end
                end
                MODE_ONESHOT: begin
                    if (!done) begin
                        if (pos == last_pos) begin
                            done_nxt = 1'b1;
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end
                end
                default: pos_nxt = pos;
            endcase
        end
    end

    // Window lookup: digit index d counts from the right, k counts from the left.
    always_comb begin
        k_left = PW'(NUM_DIGITS - 1) - PW'(digit);
        idx    = pos + k_left;
        if (idx >= stream_len) begin
            idx = idx - stream_len;
        end
        rel     = idx - PW'(NUM_DIGITS);
        seg_nxt = BLANK;
        if (!done && idx >= PW'(NUM_DIGITS)) begin
            seg_nxt = msg_buf[rel[AW-1:0]];
        end
        an_nxt = ~(NUM_DIGITS'(1) << digit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_MAX; i++) begin
                msg_buf[i] <= BLANK;
            end
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            mode_q      <= MODE_LEFT;
            scroll_cnt  <= '0;
            refresh_cnt <= '0;
            digit       <= DW'(NUM_DIGITS - 1);
        end else if (restart) begin
            len_q       <= len_clamped;
            mode_q      <= mode_t'(cfg_mode);
            scroll_cnt  <= '0;
            refresh_cnt <= '0;
        end else begin
            scroll_cnt <= tick ? '0 : scroll_cnt + SW'(1);
            if (refresh_wrap) begin
                refresh_cnt <= '0;
                digit       <= (digit == '0) ? DW'(NUM_DIGITS - 1) : digit - DW'(1);
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos  <= '0;
            wrap <= 1'b0;
            done <= 1'b0;
            an   <= '1;
            seg  <= BLANK;
        end else begin
            pos  <= pos_nxt;
            wrap <= wrap_nxt;
            done <= done_nxt;
            an   <= an_nxt;
            seg  <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_scroll_marquee.sv
// Directed bench for scroll_marquee: a table of restart/tick scenarios plus
// hand-written sequences for display content, hold, restart and reset corners.
module tb_scroll_marquee;

    localparam int N  = 4;
    localparam int MM = 16;
    localparam int SD = 8;
    localparam int RD = 2;

    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_O    = 7'h40;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_L    = 7'h47;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] BLANK    = 7'h7F;

    logic         clk;
    logic         reset;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [6:0]   wr_seg;
    logic [4:0]   cfg_len;
    logic [1:0]   cfg_mode;
    logic         restart;
    logic         hold;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         wrap;
    logic         done;

    int checks;
    int errors;
    int wrap_total;
    logic [6:0] frame [N];
    logic [6:0] msg [9];

    typedef struct {
        logic [1:0] mode;
        logic [4:0] len;
        int         nticks;
        int         exp_pos;
        int         exp_wraps;
        logic       exp_done;
    } vec_t;

    vec_t vecs [15];

    scroll_marquee #(
        .NUM_DIGITS (N),
        .MSG_MAX    (MM),
        .SCROLL_DIV (SD),
        .REFRESH_DIV(RD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_seg  (wr_seg),
        .cfg_len (cfg_len),
        .cfg_mode(cfg_mode),
        .restart (restart),
        .hold    (hold),
        .an      (an),
        .seg     (seg),
        .wrap    (wrap),
        .done    (done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial wrap_total = 0;
    always @(posedge clk) begin
        if (wrap === 1'b1) wrap_total <= wrap_total + 1;
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step(SD);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [6:0] val);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_seg  = val;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_restart(input logic [1:0] mode, input logic [4:0] len);
        cfg_mode = mode;
        cfg_len  = len;
        restart  = 1'b1;
        step(1);
        restart  = 1'b0;
    endtask

    // Holds for one full scroll period so p is frozen and tick alignment is kept.
    task automatic capture();
        for (int k = 0; k < N; k++) frame[k] = 7'h00;
        hold = 1'b1;
        for (int c = 0; c < 2 * N * RD / 2 * 2 / 2; c++) begin
            step(1);
            for (int b = 0; b < N; b++) begin
                if (an[b] == 1'b0) frame[N-1-b] = seg;
            end
        end
        hold = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        check({name, "_d0"}, int'(frame[0]), int'(e0));
        check({name, "_d1"}, int'(frame[1]), int'(e1));
        check({name, "_d2"}, int'(frame[2]), int'(e2));
        check({name, "_d3"}, int'(frame[3]), int'(e3));
    endtask

    initial begin
        int snap;
        checks = 0;
        errors = 0;

        msg[0] = SEG_C; msg[1] = SEG_O; msg[2] = SEG_C; msg[3] = SEG_A; msg[4] = SEG_DASH;
        msg[5] = SEG_C; msg[6] = SEG_O; msg[7] = SEG_L; msg[8] = SEG_A;

        //                mode   len    ticks pos wraps done
        vecs[0]  = '{2'b00, 5'd9,  4,  4,  0, 1'b0};
        vecs[1]  = '{2'b00, 5'd9,  13, 0,  1, 1'b0};
        vecs[2]  = '{2'b00, 5'd9,  27, 1,  2, 1'b0};
        vecs[3]  = '{2'b01, 5'd9,  1,  12, 1, 1'b0};
        vecs[4]  = '{2'b01, 5'd9,  13, 0,  1, 1'b0};
        vecs[5]  = '{2'b10, 5'd9,  12, 12, 0, 1'b0};
        vecs[6]  = '{2'b10, 5'd9,  13, 12, 1, 1'b1};
        vecs[7]  = '{2'b10, 5'd9,  33, 12, 1, 1'b1};
        vecs[8]  = '{2'b11, 5'd9,  5,  4,  0, 1'b0};
        vecs[9]  = '{2'b00, 5'd20, 19, 19, 0, 1'b0};
        vecs[10] = '{2'b00, 5'd20, 20, 0,  1, 1'b0};
        vecs[11] = '{2'b00, 5'd0,  8,  0,  2, 1'b0};
        vecs[12] = '{2'b00, 5'd0,  6,  2,  1, 1'b0};
        vecs[13] = '{2'b01, 5'd0,  3,  1,  1, 1'b0};
        vecs[14] = '{2'b11, 5'd0,  3,  4,  0, 1'b0};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_seg = '0;
        cfg_len = '0; cfg_mode = '0; restart = 1'b0; hold = 1'b0;

        // reset state
        step(3);
        check("reset_an", int'(an), 'hF);
        check("reset_seg", int'(seg), 'h7F);
        check("reset_wrap", int'(wrap), 0);
        check("reset_done", int'(done), 0);
        check("reset_pos", int'(dut.pos), 0);
        reset = 1'b0;
        capture();
        check_frame("reset_frame", BLANK, BLANK, BLANK, BLANK);

        for (int i = 0; i < 9; i++) write_entry(4'(i), msg[i]);

        // scroll-left, tick by tick
        do_restart(2'b00, 5'd9);
        tick();
        check("left_t1_pos", int'(dut.pos), 1);
        capture();
        check_frame("left_p1", BLANK, BLANK, BLANK, SEG_C);
        for (int t = 2; t <= 4; t++) begin
            tick();
            check("left_pos", int'(dut.pos), t);
        end
        capture();
        check_frame("left_p4", SEG_C, SEG_O, SEG_C, SEG_A);
        for (int t = 5; t <= 12; t++) begin
            tick();
            check("left_pos", int'(dut.pos), t);
            check("left_nowrap", int'(wrap), 0);
        end
        tick();
        check("left_t13_pos", int'(dut.pos), 0);
        check("left_t13_wrap", int'(wrap), 1);
        step(1);
        check("left_wrap_pulse_end", int'(wrap), 0);

        // table-driven scenarios
        for (int v = 0; v < 15; v++) begin
            snap = wrap_total;
            do_restart(vecs[v].mode, vecs[v].len);
            for (int t = 0; t < vecs[v].nticks; t++) tick();
            step(1);
            check($sformatf("vec%0d_pos", v), int'(dut.pos), vecs[v].exp_pos);
            check($sformatf("vec%0d_wraps", v), wrap_total - snap, vecs[v].exp_wraps);
            check($sformatf("vec%0d_done", v), int'(done), int'(vecs[v].exp_done));
        end

        // one-shot completion, display blanking, restart clears done
        do_restart(2'b10, 5'd9);
        for (int t = 0; t < 13; t++) tick();
        check("oneshot_done", int'(done), 1);
        check("oneshot_wrap", int'(wrap), 1);
        capture();
        check_frame("oneshot_blank", BLANK, BLANK, BLANK, BLANK);
        for (int t = 0; t < 20; t++) tick();
        check("oneshot_pos_stays", int'(dut.pos), 12);
        do_restart(2'b10, 5'd9);
        check("oneshot_restart_done", int'(done), 0);
        check("oneshot_restart_pos", int'(dut.pos), 0);

        // hold, restart coincident with tick under hold, divider clear
        do_restart(2'b00, 5'd9);
        tick();
        tick();
        check("hold_pre_pos", int'(dut.pos), 2);
        hold = 1'b1;
        step(5 * SD);
        check("hold_pos", int'(dut.pos), 2);
        step(SD - 1);
        cfg_mode = 2'b00; cfg_len = 5'd9; restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("hold_restart_pos", int'(dut.pos), 0);
        hold = 1'b0;
        step(3);
        do_restart(2'b00, 5'd9);
        step(SD - 1);
        check("div_clear_before", int'(dut.pos), 0);
        step(1);
        check("div_clear_tick", int'(dut.pos), 1);

        // static mode, live write, reset clears buffer
        do_restart(2'b11, 5'd9);
        step(1);
        check("static_pos", int'(dut.pos), 4);
        capture();
        check_frame("static", SEG_C, SEG_O, SEG_C, SEG_A);
        tick();
        check("static_pos_tick", int'(dut.pos), 4);
        check("static_nowrap", int'(wrap), 0);
        write_entry(4'd0, SEG_DASH);
        capture();
        check_frame("static_wr", SEG_DASH, SEG_O, SEG_C, SEG_A);
        reset = 1'b1;
        step(1);
        check("midreset_an", int'(an), 'hF);
        check("midreset_seg", int'(seg), 'h7F);
        check("midreset_pos", int'(dut.pos), 0);
        reset = 1'b0;
        do_restart(2'b11, 5'd9);
        step(1);
        capture();
        check_frame("midreset_buf", BLANK, BLANK, BLANK, BLANK);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
